// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_ctrl
//  Description : Hunts for a sync byte in the uart_rx byte stream, parses a
//                length-prefixed XOR-checked frame into a payload buffer and
//                releases verified payloads on a valid/ready stream. Bad,
//                truncated and malformed frames are discarded and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_last,
    input  logic       pl_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic [7:0] ovf_cnt
);

    localparam int              IDXW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              TMOW       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0]      C_MAX_LEN  = 8'(MAX_LEN);
    localparam logic [TMOW-1:0] C_TMO_LAST = TMOW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic [7:0]      chk_q, chk_d;
    logic [TMOW-1:0] tmo_q, tmo_d;
    logic [7:0]      buf_q [MAX_LEN];
    logic [7:0]      buf_d [MAX_LEN];
    logic [7:0]      pl_data_q, pl_data_d;
    logic            pl_valid_q, pl_valid_d;
    logic            pl_last_q, pl_last_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [7:0]      ovf_cnt_q, ovf_cnt_d;

    // Index of the final payload byte; len is always 1..MAX_LEN once stored
    logic [IDXW-1:0] w_last_idx;
    assign w_last_idx = IDXW'(len_q - 8'd1);

    // Next-state, datapath and output computation for the frame parser
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
        chk_d       = chk_q;
        tmo_d       = tmo_q;
        buf_d       = buf_q;
        pl_data_d   = pl_data_q;
        pl_valid_d  = pl_valid_q;
        pl_last_d   = pl_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (rx_valid) begin
                    // A byte on the timeout edge still wins
                    tmo_d = '0;
                    if (state_q == ST_LEN) begin
                        // SYNC_BYTE here is a length value, never a resync
                        if ((rx_data == 8'd0) || (rx_data > C_MAX_LEN)) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            len_d   = rx_data;
                            chk_d   = rx_data;
                            idx_d   = '0;
                            state_d = ST_PAYLOAD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        buf_d[idx_q] = rx_data;
                        chk_d        = chk_q ^ rx_data;
                        idx_d        = idx_q + 1'b1;
                        if (idx_q == w_last_idx) begin
                            state_d = ST_CHK;
                        end
                    end else begin
                        if (rx_data == chk_q) begin
                            frame_ok_d = 1'b1;
                            pl_valid_d = 1'b1;
                            pl_data_d  = buf_q[0];
                            pl_last_d  = (len_q == 8'd1);
                            out_idx_d  = '0;
                            state_d    = ST_OUT;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_OUT: begin
                // No room for a new frame while draining: count and drop
                if (rx_valid && (ovf_cnt_q != 8'hFF)) begin
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
                end
                if (pl_valid_q && pl_ready) begin
                    if (pl_last_q) begin
                        pl_valid_d = 1'b0;
                        pl_last_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                        pl_data_d = buf_q[out_idx_d];
                        pl_last_d = (out_idx_d == w_last_idx);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            out_idx_q   <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pl_last_q   <= pl_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // Payload storage; contents are only read after being written by a frame
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign pl_last   = pl_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
`default_nettype wire
